in_port_fifo: RTL and testbench

//  Input-port peripheral for the datapath "in Ra" instruction; the counterpart of the out-port register.

---
 rtl/in_port_fifo.sv | 91 +++++++++
 tb/tb_in_port_fifo.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/in_port_fifo.sv
// Input-port peripheral: a device pushes words into a DEPTH-entry FIFO, and the CPU pops the head into the InPort register.
// Optional sticky overrun flag is enabled with the macro INPORT_OVERRUN_EN.
module in_port_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] dev_data,
  input  logic             dev_valid,
  output logic             dev_ready,
  input  logic             InPortIn,
  input  logic             InPortOut,
  output logic [WIDTH-1:0] bus_out,
  output logic             in_avail,
  output logic [AW:0]      fifo_count,
  output logic             overrun
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic [WIDTH-1:0] in_port_reg;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // Handshake: a word transfers on any rising edge where dev_valid and dev_ready are both 1.
  // dev_ready depends only on occupancy and clr, never on dev_valid, so the device may wait on it.
  assign dev_ready = !full && !clr;
  assign push      = dev_valid && dev_ready;
  assign pop       = InPortIn && !empty && !clr;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= dev_data;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      in_port_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr      <= rd_ptr + 1'b1;
        in_port_reg <= mem[rd_ptr];
      end
      // A push and a pop on the same edge cancel out in the occupancy.
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

`ifdef INPORT_OVERRUN_EN
  logic overrun_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      overrun_q <= 1'b0;
    end else if (dev_valid && full) begin
      overrun_q <= 1'b1;
    end
  end

  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

  assign bus_out    = {WIDTH{InPortOut}} & in_port_reg;
  assign in_avail   = !empty;
  assign fifo_count = count;

endmodule

// File: tb/tb_in_port_fifo.sv
// Bench for in_port_fifo: directed scenarios followed by random traffic, checked against a queue-based reference model.
module tb_in_port_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic             clk;
  logic             clr;
  logic [WIDTH-1:0] dev_data;
  logic             dev_valid;
  logic             dev_ready;
  logic             InPortIn;
  logic             InPortOut;
  logic [WIDTH-1:0] bus_out;
  logic             in_avail;
  logic [AW:0]      fifo_count;
  logic             overrun;

  int checks = 0;
  int errors = 0;

  in_port_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .clr        (clr),
    .dev_data   (dev_data),
    .dev_valid  (dev_valid),
    .dev_ready  (dev_ready),
    .InPortIn   (InPortIn),
    .InPortOut  (InPortOut),
    .bus_out    (bus_out),
    .in_avail   (in_avail),
    .fifo_count (fifo_count),
    .overrun    (overrun)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: contents of the FIFO as a plain queue
  logic [WIDTH-1:0] model_q[$];
  logic             model_ovr = 1'b0;
  logic             model_pushed = 1'b0;
  // scoreboard: every value the InPort register is expected to take, in order
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] cur_exp = '0;

  always @(posedge clk) begin
    model_pushed = 1'b0;
    if (clr) begin
      model_q.delete();
      model_ovr = 1'b0;
      exp_q.push_back('0);
    end else begin
      logic was_full;
      logic was_empty;
      was_full  = (model_q.size() == DEPTH);
      was_empty = (model_q.size() == 0);
`ifdef INPORT_OVERRUN_EN
      if (dev_valid && was_full) model_ovr = 1'b1;
`endif
      if (InPortIn && !was_empty) exp_q.push_back(model_q.pop_front());
      if (dev_valid && !was_full) begin
        model_q.push_back(dev_data);
        model_pushed = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: compares the DUT's visible outputs just after each edge
  always begin
    @(posedge clk);
    #1;
    while (exp_q.size() > 0) cur_exp = exp_q.pop_front();
    chk("bus_out",    bus_out, InPortOut ? cur_exp : '0);
    chk("fifo_count", WIDTH'(fifo_count), WIDTH'(model_q.size()));
    chk("in_avail",   WIDTH'(in_avail), WIDTH'(model_q.size() != 0));
    chk("dev_ready",  WIDTH'(dev_ready), WIDTH'((model_q.size() < DEPTH) && !clr));
    chk("overrun",    WIDTH'(overrun), WIDTH'(model_ovr));
  end

  // driver: apply inputs on the falling edge, return just after the next rising edge
  task automatic cyc(input logic c, input logic v, input logic [WIDTH-1:0] d,
                     input logic pi, input logic po);
    @(negedge clk);
    clr       = c;
    dev_valid = v;
    dev_data  = d;
    InPortIn  = pi;
    InPortOut = po;
    @(posedge clk);
    #2;
  endtask

  initial begin
    clr = 1'b1; dev_valid = 1'b0; dev_data = '0; InPortIn = 1'b0; InPortOut = 1'b0;

    // basic in
    cyc(1, 0, 0, 0, 0);
    chk("reset_count", WIDTH'(fifo_count), 0);
    chk("reset_ready_in_clr", WIDTH'(dev_ready), 0);
    cyc(0, 1, 32'h0000_000A, 0, 0);
    chk("push_avail", WIDTH'(in_avail), 1);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1);
    chk("basic_bus", bus_out, 32'h0000_000A);
    chk("basic_avail_after", WIDTH'(in_avail), 0);

    // empty pop keeps the register
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1);
    chk("empty_pop_bus", bus_out, 32'h0000_000A);
    chk("empty_pop_count", WIDTH'(fifo_count), 0);
    cyc(0, 0, 0, 0, 0);
    chk("bus_gated", bus_out, 0);

    // fill / full, 5th word refused
    cyc(0, 1, 32'h11, 0, 0);
    cyc(0, 1, 32'h22, 0, 0);
    cyc(0, 1, 32'h33, 0, 0);
    cyc(0, 1, 32'h44, 0, 0);
    chk("full_count", WIDTH'(fifo_count), 4);
    chk("full_ready", WIDTH'(dev_ready), 0);
    cyc(0, 1, 32'h55, 0, 0);
    chk("full_no_push", WIDTH'(fifo_count), 4);

    // pop with dev_valid while full
    cyc(0, 1, 32'h55, 1, 1);
    chk("full_simul_count", WIDTH'(fifo_count), 3);
    chk("full_simul_ready", WIDTH'(dev_ready), 1);
    chk("pop_11", bus_out, 32'h11);
    cyc(0, 0, 0, 1, 1);
    chk("pop_22", bus_out, 32'h22);
    cyc(0, 0, 0, 1, 1);
    chk("pop_33", bus_out, 32'h33);
    cyc(0, 0, 0, 1, 1);
    chk("pop_44", bus_out, 32'h44);

    // push and pop on an empty FIFO: only the push happens
    cyc(0, 1, 32'h77, 1, 1);
    chk("empty_simul_count", WIDTH'(fifo_count), 1);
    chk("empty_simul_reg", bus_out, 32'h44);
    cyc(0, 0, 0, 1, 1);
    chk("pop_77", bus_out, 32'h77);

    // wrap
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, WIDTH'(32'h100 + i), 0, 0);
      cyc(0, 0, 0, 1, 1);
      chk("wrap_pop", bus_out, WIDTH'(32'h100 + i));
    end

    // reset mid-operation
    cyc(0, 1, 32'hA1, 0, 0);
    cyc(0, 1, 32'hA2, 0, 0);
    cyc(0, 1, 32'hA3, 0, 0);
    cyc(1, 1, 32'hA4, 1, 1);
    chk("midclr_count", WIDTH'(fifo_count), 0);
    chk("midclr_reg", bus_out, 0);

    // overrun: fill and keep dev_valid high
    for (int i = 0; i < 6; i++) cyc(0, 1, WIDTH'(32'hB0 + i), 0, 0);
`ifdef INPORT_OVERRUN_EN
    chk("overrun_set", WIDTH'(overrun), 1);
    cyc(0, 0, 0, 1, 0);
    chk("overrun_sticky", WIDTH'(overrun), 1);
`else
    chk("overrun_tied", WIDTH'(overrun), 0);
`endif
    cyc(1, 0, 0, 0, 0);
    chk("overrun_clr", WIDTH'(overrun), 0);

    // random traffic; an unaccepted word is held until taken
    for (int i = 0; i < 600; i++) begin
      logic [WIDTH-1:0] d;
      logic v;
      logic hold;
      hold = dev_valid && !model_pushed && !clr;
      v = hold ? 1'b1 : ($urandom_range(0, 3) != 0);
      d = hold ? dev_data : WIDTH'($urandom);
      cyc(($urandom_range(0, 49) == 0), v, d, ($urandom_range(0, 2) == 0), $urandom_range(0, 1) == 1);
    end
    cyc(0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
